// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, one-cycle redirect pulse and wrong-path squash.
// Optional macro EX_BRANCH_STATS_EN adds accepted/taken branch counters.
module ex_mem_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        in_valid_i,
  input  logic [31:0] rslt_i,
  input  logic [3:0]  flag_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] write_data_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        jalr_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic [1:0]  result_src_i,
  output logic        out_valid_o,
  output logic [31:0] alu_rslt_o,
  output logic [31:0] write_data_o,
  output logic [31:0] pc_plus4_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_write_o,
  output logic [1:0]  result_src_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
`ifdef EX_BRANCH_STATS_EN
  output logic [31:0] br_count_o,
  output logic [31:0] br_taken_o,
`endif
  output logic        squash_o
);

  typedef enum logic {IDLE, SQUASH} state_t;

  localparam logic [1:0] DEPTH = 2'(SQUASH_DEPTH);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        w_accept, w_cond, w_br_taken, w_taken;
  logic [31:0] w_target;

  // flag_i = {Ovf, Carry, Neg, Zero}
  always_comb begin
    w_cond = 1'b0;
    case (funct3_i)
      3'b000:  w_cond = flag_i[0];
      3'b001:  w_cond = ~flag_i[0];
      3'b100:  w_cond = flag_i[1] ^ flag_i[3];
      3'b101:  w_cond = ~(flag_i[1] ^ flag_i[3]);
      3'b110:  w_cond = ~flag_i[2];
      3'b111:  w_cond = flag_i[2];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_accept   = in_valid_i && (r_state == IDLE);
  assign w_br_taken = branch_i & w_cond;
  assign w_taken    = w_accept & (w_br_taken | jump_i | jalr_i);
  assign w_target   = jalr_i ? (rslt_i & 32'hFFFF_FFFE) : (pc_i + imm_i);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!stall_i) begin
      case (r_state)
        IDLE: begin
          if (w_taken) begin
            w_state_nxt = SQUASH;
            w_cnt_nxt   = DEPTH;
          end
        end
        SQUASH: begin
          // only real wrong-path instructions consume a squash slot
          if (in_valid_i) begin
            w_cnt_nxt = r_cnt - 2'd1;
            if (r_cnt == 2'd1) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= 2'd0;
      out_valid_o   <= 1'b0;
      reg_write_o   <= 1'b0;
      mem_write_o   <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
      alu_rslt_o    <= 32'd0;
      write_data_o  <= 32'd0;
      pc_plus4_o    <= 32'd0;
      rd_o          <= 5'd0;
      result_src_o  <= 2'd0;
    end else if (!stall_i) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      out_valid_o <= w_accept;
      reg_write_o <= w_accept & reg_write_i;
      mem_write_o <= w_accept & mem_write_i;
      redirect_o  <= w_taken;
      if (w_taken) redirect_pc_o <= w_target;
      // bubbles leave the data fields untouched
      if (w_accept) begin
        alu_rslt_o   <= rslt_i;
        write_data_o <= write_data_i;
        pc_plus4_o   <= pc_i + 32'd4;
        rd_o         <= rd_i;
        result_src_o <= result_src_i;
      end
    end
  end

  assign squash_o = (r_state == SQUASH);

`ifdef EX_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_o <= 32'd0;
      br_taken_o <= 32'd0;
    end else if (!stall_i && w_accept && branch_i) begin
      br_count_o <= br_count_o + 32'd1;
      if (w_br_taken) br_taken_o <= br_taken_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage with a per-cycle expectation queue and an independent monitor.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, in_valid_i, branch_i, jump_i, jalr_i, reg_write_i, mem_write_i;
  logic [31:0] rslt_i, pc_i, imm_i, write_data_i;
  logic [3:0]  flag_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [1:0]  result_src_i;
  logic        out_valid_o, reg_write_o, mem_write_o, redirect_o, squash_o;
  logic [31:0] alu_rslt_o, write_data_o, pc_plus4_o, redirect_pc_o;
  logic [4:0]  rd_o;
  logic [1:0]  result_src_o;
`ifdef EX_BRANCH_STATS_EN
  logic [31:0] br_count_o, br_taken_o;
`endif

  always #5 clk = ~clk;

  ex_mem_stage #(.SQUASH_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .in_valid_i(in_valid_i),
    .rslt_i(rslt_i), .flag_i(flag_i), .pc_i(pc_i), .imm_i(imm_i),
    .write_data_i(write_data_i), .branch_i(branch_i), .jump_i(jump_i),
    .jalr_i(jalr_i), .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i), .result_src_i(result_src_i),
    .out_valid_o(out_valid_o), .alu_rslt_o(alu_rslt_o), .write_data_o(write_data_o),
    .pc_plus4_o(pc_plus4_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o), .result_src_o(result_src_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
`ifdef EX_BRANCH_STATS_EN
    .br_count_o(br_count_o), .br_taken_o(br_taken_o),
`endif
    .squash_o(squash_o)
  );

  typedef struct packed {
    logic        stall, vld;
    logic [31:0] rslt, pc, imm, wd;
    logic [3:0]  flag;
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [1:0]  rs;
  } in_t;

  typedef struct packed {
    logic        vld, rw, mw, redir, sq, chk_data;
    logic [31:0] alu, pcp4, wd, rpc;
    logic [4:0]  rd;
    logic [1:0]  rs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic in_t nop();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t alu_op(input logic [31:0] rslt, input logic [4:0] rd, input logic [31:0] pc);
    in_t v;
    v = '0;
    v.vld = 1'b1; v.rslt = rslt; v.rd = rd; v.rw = 1'b1; v.pc = pc;
    return v;
  endfunction

  function automatic in_t br_op(input logic [2:0] f3, input logic [3:0] flag,
                                input logic [31:0] pc, input logic [31:0] imm);
    in_t v;
    v = '0;
    v.vld = 1'b1; v.br = 1'b1; v.f3 = f3; v.flag = flag; v.pc = pc; v.imm = imm;
    return v;
  endfunction

  function automatic exp_t acc(input logic [31:0] alu, input logic [31:0] pcp4, input logic [31:0] wd,
                               input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rs,
                               input logic redir, input logic [31:0] rpc, input logic sq);
    exp_t e;
    e = '0;
    e.vld = 1'b1; e.chk_data = 1'b1; e.alu = alu; e.pcp4 = pcp4; e.wd = wd; e.rd = rd;
    e.rw = rw; e.mw = mw; e.rs = rs; e.redir = redir; e.rpc = rpc; e.sq = sq;
    return e;
  endfunction

  function automatic exp_t bub(input logic sq);
    exp_t e;
    e = '0;
    e.sq = sq;
    return e;
  endfunction

  task automatic apply(input in_t v);
    stall_i = v.stall; in_valid_i = v.vld; rslt_i = v.rslt; pc_i = v.pc; imm_i = v.imm;
    write_data_i = v.wd; flag_i = v.flag; branch_i = v.br; jump_i = v.jal; jalr_i = v.jalr;
    funct3_i = v.f3; rd_i = v.rd; reg_write_i = v.rw; mem_write_i = v.mw; result_src_i = v.rs;
  endtask

  task automatic drive(input in_t v, input exp_t e);
    @(negedge clk);
    apply(v);
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_reg_write"}, {31'd0, reg_write_o}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write_o}, 32'd0);
    chk({tag, "_redirect"}, {31'd0, redirect_o}, 32'd0);
    chk({tag, "_squash"}, {31'd0, squash_o}, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc_o, 32'd0);
    chk({tag, "_alu"}, alu_rslt_o, 32'd0);
    chk({tag, "_wdata"}, write_data_o, 32'd0);
    chk({tag, "_pc_plus4"}, pc_plus4_o, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
    chk({tag, "_result_src"}, {30'd0, result_src_o}, 32'd0);
  endtask

  // Monitor: one expectation per clock edge while out of reset
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid", {31'd0, out_valid_o}, {31'd0, e.vld});
        chk("reg_write", {31'd0, reg_write_o}, {31'd0, e.rw});
        chk("mem_write", {31'd0, mem_write_o}, {31'd0, e.mw});
        chk("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
        chk("squash", {31'd0, squash_o}, {31'd0, e.sq});
        if (e.redir) chk("redirect_pc", redirect_pc_o, e.rpc);
        if (e.chk_data) begin
          chk("alu_rslt", alu_rslt_o, e.alu);
          chk("pc_plus4", pc_plus4_o, e.pcp4);
          chk("write_data", write_data_o, e.wd);
          chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
          chk("result_src", {30'd0, result_src_o}, {30'd0, e.rs});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t  v;
    exp_t e;
    rst_n = 1'b0;
    apply(nop());
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // plain add, then taken beq with squash of two valid inputs (an invalid one in between)
    drive(alu_op(32'h10, 5'd5, 32'h0), acc(32'h10, 32'h4, 32'h0, 5'd5, 1, 0, 2'd0, 0, 32'h0, 0));
    drive(br_op(3'b000, 4'b0001, 32'h100, 32'h20),
          acc(32'h0, 32'h104, 32'h0, 5'd0, 0, 0, 2'd0, 1, 32'h120, 1));
    drive(alu_op(32'h33, 5'd6, 32'h104), bub(1));
    drive(nop(), bub(1));
    v = alu_op(32'h55, 5'd8, 32'h108); v.mw = 1'b1; v.jal = 1'b1;
    drive(v, bub(0));
    drive(alu_op(32'h44, 5'd7, 32'h200), acc(32'h44, 32'h204, 32'h0, 5'd7, 1, 0, 2'd0, 0, 32'h0, 0));

    // bltu not taken, bgeu taken with Carry=1
    drive(br_op(3'b110, 4'b0100, 32'h300, 32'h40),
          acc(32'h0, 32'h304, 32'h0, 5'd0, 0, 0, 2'd0, 0, 32'h0, 0));
    drive(br_op(3'b111, 4'b0100, 32'h300, 32'h40),
          acc(32'h0, 32'h304, 32'h0, 5'd0, 0, 0, 2'd0, 1, 32'h340, 1));
    drive(alu_op(32'h1, 5'd1, 32'h304), bub(1));
    drive(alu_op(32'h2, 5'd2, 32'h308), bub(0));

    // jalr clears bit 0 of the target; pc+4 wraps to zero
    v = alu_op(32'h203, 5'd1, 32'hFFFF_FFFC); v.jalr = 1'b1; v.rs = 2'd2; v.imm = 32'h8;
    drive(v, acc(32'h203, 32'h0, 32'h0, 5'd1, 1, 0, 2'd2, 1, 32'h202, 1));
    drive(alu_op(32'h3, 5'd3, 32'h0), bub(1));
    drive(alu_op(32'h4, 5'd4, 32'h4), bub(0));

    // bne taken with negative offset, then 3 stalled cycles holding everything
    v = br_op(3'b001, 4'b0000, 32'h400, 32'hFFFF_FFF0); v.rslt = 32'h77;
    e = acc(32'h77, 32'h404, 32'h0, 5'd0, 0, 0, 2'd0, 1, 32'h3F0, 1);
    drive(v, e);
    v = alu_op(32'h99, 5'd9, 32'h404); v.stall = 1'b1; v.jal = 1'b1;
    for (int i = 0; i < 3; i++) drive(v, e);
    v.stall = 1'b0;
    drive(v, bub(1));
    drive(alu_op(32'h5, 5'd5, 32'h408), bub(0));
    drive(alu_op(32'h66, 5'd10, 32'h3F0), acc(32'h66, 32'h3F4, 32'h0, 5'd10, 1, 0, 2'd0, 0, 32'h0, 0));

    // blt not taken (Neg=Ovf=1), funct3 010 never taken, bge taken
    drive(br_op(3'b100, 4'b1010, 32'h600, 32'h10),
          acc(32'h0, 32'h604, 32'h0, 5'd0, 0, 0, 2'd0, 0, 32'h0, 0));
    drive(br_op(3'b010, 4'b1111, 32'h604, 32'h10),
          acc(32'h0, 32'h608, 32'h0, 5'd0, 0, 0, 2'd0, 0, 32'h0, 0));
    drive(br_op(3'b101, 4'b1010, 32'h600, 32'h10),
          acc(32'h0, 32'h604, 32'h0, 5'd0, 0, 0, 2'd0, 1, 32'h610, 1));
    drive(alu_op(32'h6, 5'd6, 32'h604), bub(1));
    drive(alu_op(32'h7, 5'd7, 32'h608), bub(0));

    // jal, one squashed slot, then asynchronous reset mid-squash
    v = nop(); v.vld = 1'b1; v.jal = 1'b1; v.pc = 32'h500; v.imm = 32'h8; v.rd = 5'd1; v.rw = 1'b1; v.rs = 2'd2;
    drive(v, acc(32'h0, 32'h504, 32'h0, 5'd1, 1, 0, 2'd2, 1, 32'h508, 1));
    drive(alu_op(32'h8, 5'd8, 32'h504), bub(1));
    #2;
    apply(nop());
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(alu_op(32'hAB, 5'd11, 32'h800), acc(32'hAB, 32'h804, 32'h0, 5'd11, 1, 0, 2'd0, 0, 32'h0, 0));

    // store
    v = nop(); v.vld = 1'b1; v.mw = 1'b1; v.wd = 32'hDEAD_BEEF; v.rslt = 32'h1000; v.pc = 32'h700; v.rs = 2'd1;
    drive(v, acc(32'h1000, 32'h704, 32'hDEAD_BEEF, 5'd0, 0, 1, 2'd1, 0, 32'h0, 0));
    drive(nop(), bub(0));

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
